// File: rtl/regfile_writeback.sv
// Purpose : write-side front end of the 2R/1W register file; buffers writeback requests in order and drives one write per cycle.
// Latency : an entry accepted at edge N pops at edge N+1 at the earliest (o_we high N+1..N+2), committed by the regfile at N+2.
// Backpr. : o_ready drops when the queue is full, during i_flush and while in reset; i_stall holds entries in the queue.
//
// Ports:
//   r_clk / r_rst             clock, asynchronous active-low reset
//   i_valid/o_ready/i_addr/i_data   writeback request handshake
//   i_stall / i_flush         pop inhibit / synchronous queue clear
//   o_we/o_addr_rd/o_data_rd  registered register file write port
//   o_count / o_empty         queue occupancy
//   i_addr_rs*/o_hit_rs*/o_data_rs*  read bypass of pending writes
//
// Build option: define WB_BYPASS_EN to build the bypass search; without it
// the bypass outputs are tied to zero.
module regfile_writeback #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     r_clk,
    input  logic                     r_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [AWIDTH-1:0]        i_addr,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_we,
    output logic [AWIDTH-1:0]        o_addr_rd,
    output logic [DWIDTH-1:0]        o_data_rd,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    input  logic [AWIDTH-1:0]        i_addr_rs1,
    input  logic [AWIDTH-1:0]        i_addr_rs2,
    output logic                     o_hit_rs1,
    output logic                     o_hit_rs2,
    output logic [DWIDTH-1:0]        o_data_rs1,
    output logic [DWIDTH-1:0]        o_data_rs2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AWIDTH-1:0] r_mem_addr [DEPTH];
    logic [DWIDTH-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_we;
    logic [AWIDTH-1:0] r_addr_rd;
    logic [DWIDTH-1:0] r_data_rd;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Ready looks only at the registered count: a pop in the same cycle
    // never frees a slot for a push while full.
    assign w_full  = (r_count == CW'(DEPTH));
    assign o_ready = !w_full && !i_flush && r_rst;

    // Writes to x0 complete the handshake but are never stored.
    assign w_push  = i_valid && o_ready && (i_addr != '0);
    assign w_pop   = !i_stall && (r_count != '0) && !i_flush;

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_addr_rd <= '0;
            r_data_rd <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head    <= r_head + PW'(1);
                r_we      <= 1'b1;
                r_addr_rd <= r_mem_addr[r_head];
                r_data_rd <= r_mem_data[r_head];
            end else begin
                r_we <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge r_clk) begin
        if (w_push) begin
            r_mem_addr[r_tail] <= i_addr;
            r_mem_data[r_tail] <= i_data;
        end
    end

    assign o_we      = r_we;
    assign o_addr_rd = r_addr_rd;
    assign o_data_rd = r_data_rd;
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);

`ifdef WB_BYPASS_EN
    logic              w_hit_rs1;
    logic              w_hit_rs2;
    logic [DWIDTH-1:0] w_data_rs1;
    logic [DWIDTH-1:0] w_data_rs2;
    logic [PW-1:0]     w_idx;

    // Scan oldest to newest so later matches override earlier ones; the
    // output register is the oldest pending write and is seeded first.
    always_comb begin
        w_hit_rs1  = 1'b0;
        w_hit_rs2  = 1'b0;
        w_data_rs1 = '0;
        w_data_rs2 = '0;
        w_idx      = '0;
        if (r_we && (r_addr_rd == i_addr_rs1)) begin
            w_hit_rs1  = 1'b1;
            w_data_rs1 = r_data_rd;
        end
        if (r_we && (r_addr_rd == i_addr_rs2)) begin
            w_hit_rs2  = 1'b1;
            w_data_rs2 = r_data_rd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if (r_mem_addr[w_idx] == i_addr_rs1) begin
                    w_hit_rs1  = 1'b1;
                    w_data_rs1 = r_mem_data[w_idx];
                end
                if (r_mem_addr[w_idx] == i_addr_rs2) begin
                    w_hit_rs2  = 1'b1;
                    w_data_rs2 = r_mem_data[w_idx];
                end
            end
        end
        // x0 always reads as zero, so it must never be forwarded.
        if (i_addr_rs1 == '0) begin
            w_hit_rs1  = 1'b0;
            w_data_rs1 = '0;
        end
        if (i_addr_rs2 == '0) begin
            w_hit_rs2  = 1'b0;
            w_data_rs2 = '0;
        end
    end

    assign o_hit_rs1  = w_hit_rs1;
    assign o_hit_rs2  = w_hit_rs2;
    assign o_data_rs1 = w_data_rs1;
    assign o_data_rs2 = w_data_rs2;
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_addr_rs1, i_addr_rs2};

    assign o_hit_rs1  = 1'b0;
    assign o_hit_rs2  = 1'b0;
    assign o_data_rs1 = '0;
    assign o_data_rs2 = '0;
`endif

endmodule
